// File: rtl/can_host_mailbox.sv
// rtl/can_host_mailbox.sv - host-side TX/RX mailbox responder for one CAN node (optional feature macro: RETX_PRIO_EN)
module can_host_mailbox #(
    parameter int                DATA_SIZE = 64,
    parameter int                ID_SIZE   = 11,
    parameter int                TX_DEPTH  = 4,
    parameter int                RX_DEPTH  = 4,
    parameter int                MAX_RETRY = 3,
    parameter logic [ID_SIZE-1:0] IDLE_ID  = {ID_SIZE{1'b1}}
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tx_push,
    input  logic [DATA_SIZE-1:0] tx_data,
    input  logic [ID_SIZE-1:0]   tx_id,
    input  logic [ID_SIZE-1:0]   tx_rx_id,
    output logic                 tx_full,
    output logic                 tx_done,
    output logic                 tx_abort,
    output logic                 tx_underrun,
    input  logic                 rx_pop,
    output logic [DATA_SIZE-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_overflow,
    input  logic                 rx_ovf_clr,
    input  logic                 data_in_req,
    input  logic                 data_out_req,
    input  logic [DATA_SIZE-1:0] Rx_packet,
    input  logic                 Retransmit,
    output logic [DATA_SIZE-1:0] In_packet,
    output logic [ID_SIZE-1:0]   Tx_ID,
    output logic [ID_SIZE-1:0]   Rx_ID
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;

    localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
    localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);
    localparam logic [3:0]       RETRY_LIM   = 4'(MAX_RETRY);

    typedef enum logic {
        ST_IDLE,
        ST_INFLIGHT
    } state_t;

    // ---------------- TX mailbox FIFO ----------------
    logic [DATA_SIZE-1:0] r_tx_data [TX_DEPTH];
    logic [ID_SIZE-1:0]   r_tx_id   [TX_DEPTH];
    logic [ID_SIZE-1:0]   r_tx_rxid [TX_DEPTH];
    logic [TX_AW-1:0]     r_tx_wr_ptr;
    logic [TX_AW-1:0]     r_tx_rd_ptr;
    logic [TX_CW-1:0]     r_tx_count;

    logic w_tx_empty;
    logic w_tx_full;
    logic w_tx_pop;
    logic w_tx_wr;

    assign w_tx_empty = (r_tx_count == '0);
    assign w_tx_full  = (r_tx_count == TX_FULL_CNT);
    // A request always consumes the head when one exists; a push into a full
    // FIFO is only accepted when that pop frees a slot in the same cycle.
    assign w_tx_pop   = data_in_req & ~w_tx_empty;
    assign w_tx_wr    = tx_push & (~w_tx_full | w_tx_pop);
    assign tx_full    = w_tx_full;

    // TX storage write; contents need no reset because the pointers gate reads
    always_ff @(posedge clock) begin
        if (w_tx_wr) begin
            r_tx_data[r_tx_wr_ptr] <= tx_data;
            r_tx_id[r_tx_wr_ptr]   <= tx_id;
            r_tx_rxid[r_tx_wr_ptr] <= tx_rx_id;
        end
    end

    // TX pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_count  <= '0;
        end else begin
            if (w_tx_wr) begin
                r_tx_wr_ptr <= r_tx_wr_ptr + TX_AW'(1);
            end
            if (w_tx_pop) begin
                r_tx_rd_ptr <= r_tx_rd_ptr + TX_AW'(1);
            end
            case ({w_tx_wr, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + TX_CW'(1);
                2'b01:   r_tx_count <= r_tx_count - TX_CW'(1);
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    // ---------------- Request/retry FSM ----------------
    state_t               r_state;
    state_t               w_nxt_state;
    logic [3:0]           r_retry_cnt;
    logic [3:0]           w_nxt_retry;
    logic [DATA_SIZE-1:0] r_in_packet;
    logic [DATA_SIZE-1:0] w_nxt_in_packet;
    logic [ID_SIZE-1:0]   r_tx_id_out;
    logic [ID_SIZE-1:0]   w_nxt_tx_id;
    logic [ID_SIZE-1:0]   r_rx_id_out;
    logic [ID_SIZE-1:0]   w_nxt_rx_id;
    logic                 r_tx_done;
    logic                 w_nxt_done;
    logic                 r_tx_abort;
    logic                 w_nxt_abort;
    logic                 r_tx_underrun;
    logic                 w_nxt_underrun;

    // State and registered node-facing outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_retry_cnt   <= '0;
            r_in_packet   <= '0;
            r_tx_id_out   <= IDLE_ID;
            r_rx_id_out   <= '0;
            r_tx_done     <= 1'b0;
            r_tx_abort    <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_retry_cnt   <= w_nxt_retry;
            r_in_packet   <= w_nxt_in_packet;
            r_tx_id_out   <= w_nxt_tx_id;
            r_rx_id_out   <= w_nxt_rx_id;
            r_tx_done     <= w_nxt_done;
            r_tx_abort    <= w_nxt_abort;
            r_tx_underrun <= w_nxt_underrun;
        end
    end

    // Next state: a new request always wins over a same-cycle Retransmit
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_retry     = r_retry_cnt;
        w_nxt_in_packet = r_in_packet;
        w_nxt_tx_id     = r_tx_id_out;
        w_nxt_rx_id     = r_rx_id_out;
        w_nxt_done      = 1'b0;
        w_nxt_abort     = 1'b0;
        w_nxt_underrun  = 1'b0;

        if (data_in_req) begin
            // Asking for the next frame implies the previous one went out.
            w_nxt_done  = (r_state == ST_INFLIGHT);
            w_nxt_retry = '0;
            if (!w_tx_empty) begin
                w_nxt_in_packet = r_tx_data[r_tx_rd_ptr];
                w_nxt_tx_id     = r_tx_id[r_tx_rd_ptr];
                w_nxt_rx_id     = r_tx_rxid[r_tx_rd_ptr];
                w_nxt_state     = ST_INFLIGHT;
            end else begin
                w_nxt_in_packet = '0;
                w_nxt_tx_id     = IDLE_ID;
                w_nxt_rx_id     = '0;
                w_nxt_underrun  = 1'b1;
                w_nxt_state     = ST_IDLE;
            end
        end else if (Retransmit && (r_state == ST_INFLIGHT)) begin
            if (r_retry_cnt < RETRY_LIM) begin
                w_nxt_retry = r_retry_cnt + 4'd1;
`ifdef RETX_PRIO_EN
                // Highest arbitration priority for the resend; the original
                // identifier is deliberately not restored on later retries.
                w_nxt_tx_id = '0;
`endif
            end else begin
                w_nxt_abort     = 1'b1;
                w_nxt_retry     = '0;
                w_nxt_in_packet = '0;
                w_nxt_tx_id     = IDLE_ID;
                w_nxt_rx_id     = '0;
                w_nxt_state     = ST_IDLE;
            end
        end
    end

    assign In_packet   = r_in_packet;
    assign Tx_ID       = r_tx_id_out;
    assign Rx_ID       = r_rx_id_out;
    assign tx_done     = r_tx_done;
    assign tx_abort    = r_tx_abort;
    assign tx_underrun = r_tx_underrun;

    // ---------------- RX mailbox FIFO ----------------
    logic [DATA_SIZE-1:0] r_rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]     r_rx_wr_ptr;
    logic [RX_AW-1:0]     r_rx_rd_ptr;
    logic [RX_CW-1:0]     r_rx_count;
    logic                 r_rx_overflow;

    logic w_rx_empty;
    logic w_rx_full;
    logic w_rx_pop;
    logic w_rx_wr;
    logic w_rx_ovf;

    assign w_rx_empty = (r_rx_count == '0);
    assign w_rx_full  = (r_rx_count == RX_FULL_CNT);
    assign w_rx_pop   = rx_pop & ~w_rx_empty;
    assign w_rx_wr    = data_out_req & (~w_rx_full | w_rx_pop);
    assign w_rx_ovf   = data_out_req & w_rx_full & ~w_rx_pop;

    // RX storage write
    always_ff @(posedge clock) begin
        if (w_rx_wr) begin
            r_rx_mem[r_rx_wr_ptr] <= Rx_packet;
        end
    end

    // RX pointers, occupancy and sticky overflow (a new overflow beats clear)
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_wr_ptr   <= '0;
            r_rx_rd_ptr   <= '0;
            r_rx_count    <= '0;
            r_rx_overflow <= 1'b0;
        end else begin
            if (w_rx_wr) begin
                r_rx_wr_ptr <= r_rx_wr_ptr + RX_AW'(1);
            end
            if (w_rx_pop) begin
                r_rx_rd_ptr <= r_rx_rd_ptr + RX_AW'(1);
            end
            case ({w_rx_wr, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + RX_CW'(1);
                2'b01:   r_rx_count <= r_rx_count - RX_CW'(1);
                default: r_rx_count <= r_rx_count;
            endcase
            if (w_rx_ovf) begin
                r_rx_overflow <= 1'b1;
            end else if (rx_ovf_clr) begin
                r_rx_overflow <= 1'b0;
            end
        end
    end

    assign rx_data     = r_rx_mem[r_rx_rd_ptr];
    assign rx_valid    = ~w_rx_empty;
    assign rx_overflow = r_rx_overflow;

endmodule

// File: tb/tb_can_host_mailbox.sv
// tb/tb_can_host_mailbox.sv - randomized self-checking bench for can_host_mailbox
module tb_can_host_mailbox;

    localparam int DEPTH = 4;
    localparam int MAXR  = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        tx_push;
    logic [63:0] tx_data;
    logic [10:0] tx_id;
    logic [10:0] tx_rx_id;
    logic        tx_full;
    logic        tx_done;
    logic        tx_abort;
    logic        tx_underrun;
    logic        rx_pop;
    logic [63:0] rx_data;
    logic        rx_valid;
    logic        rx_overflow;
    logic        rx_ovf_clr;
    logic        data_in_req;
    logic        data_out_req;
    logic [63:0] Rx_packet;
    logic        Retransmit;
    logic [63:0] In_packet;
    logic [10:0] Tx_ID;
    logic [10:0] Rx_ID;

    always #5 clock = ~clock;

    can_host_mailbox dut (
        .clock        (clock),
        .reset        (reset),
        .tx_push      (tx_push),
        .tx_data      (tx_data),
        .tx_id        (tx_id),
        .tx_rx_id     (tx_rx_id),
        .tx_full      (tx_full),
        .tx_done      (tx_done),
        .tx_abort     (tx_abort),
        .tx_underrun  (tx_underrun),
        .rx_pop       (rx_pop),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_overflow  (rx_overflow),
        .rx_ovf_clr   (rx_ovf_clr),
        .data_in_req  (data_in_req),
        .data_out_req (data_out_req),
        .Rx_packet    (Rx_packet),
        .Retransmit   (Retransmit),
        .In_packet    (In_packet),
        .Tx_ID        (Tx_ID),
        .Rx_ID        (Rx_ID)
    );

    typedef struct {
        logic [63:0] d;
        logic [10:0] id;
        logic [10:0] rid;
    } frame_t;

    frame_t      tx_q[$];
    logic [63:0] rx_q[$];
    bit          m_inflight;
    int          m_retry;
    logic [63:0] m_in;
    logic [10:0] m_txid;
    logic [10:0] m_rxid;
    bit          m_done;
    bit          m_abort;
    bit          m_under;
    bit          m_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        reset        = 1'b0;
        tx_push      = 1'b0;
        tx_data      = '0;
        tx_id        = '0;
        tx_rx_id     = '0;
        rx_pop       = 1'b0;
        rx_ovf_clr   = 1'b0;
        data_in_req  = 1'b0;
        data_out_req = 1'b0;
        Rx_packet    = '0;
        Retransmit   = 1'b0;
    endtask

    // Reference behaviour for one clock edge, from current inputs
    task automatic model_step();
        frame_t head;
        bit     has_head;
        bit     rx_pop_ok;
        bit     rx_accept;
        bit     ovf_set;
        m_done  = 0;
        m_abort = 0;
        m_under = 0;
        if (reset) begin
            tx_q.delete();
            rx_q.delete();
            m_inflight = 0;
            m_retry    = 0;
            m_in       = '0;
            m_txid     = 11'h7FF;
            m_rxid     = '0;
            m_ovf      = 0;
            return;
        end
        has_head = (tx_q.size() > 0);
        if (has_head) head = tx_q[0];
        if (data_in_req) begin
            m_done  = m_inflight;
            m_retry = 0;
            if (has_head) begin
                void'(tx_q.pop_front());
                m_in = head.d; m_txid = head.id; m_rxid = head.rid;
                m_inflight = 1;
            end else begin
                m_in = '0; m_txid = 11'h7FF; m_rxid = '0;
                m_under = 1;
                m_inflight = 0;
            end
        end else if (Retransmit && m_inflight) begin
            if (m_retry < MAXR) begin
                m_retry++;
`ifdef RETX_PRIO_EN
                m_txid = '0;
`endif
            end else begin
                m_abort = 1;
                m_retry = 0;
                m_in = '0; m_txid = 11'h7FF; m_rxid = '0;
                m_inflight = 0;
            end
        end
        if (tx_push && (tx_q.size() < DEPTH)) begin
            frame_t f;
            f.d = tx_data; f.id = tx_id; f.rid = tx_rx_id;
            tx_q.push_back(f);
        end
        rx_pop_ok = rx_pop && (rx_q.size() > 0);
        rx_accept = 0;
        ovf_set   = 0;
        if (data_out_req) begin
            if ((rx_q.size() < DEPTH) || rx_pop_ok) rx_accept = 1;
            else ovf_set = 1;
        end
        if (rx_pop_ok) void'(rx_q.pop_front());
        if (rx_accept) rx_q.push_back(Rx_packet);
        if (ovf_set) m_ovf = 1;
        else if (rx_ovf_clr) m_ovf = 0;
    endtask

    task automatic check_all();
        check("In_packet", In_packet, m_in);
        check("Tx_ID", 64'(Tx_ID), 64'(m_txid));
        check("Rx_ID", 64'(Rx_ID), 64'(m_rxid));
        check("tx_done", 64'(tx_done), 64'(m_done));
        check("tx_abort", 64'(tx_abort), 64'(m_abort));
        check("tx_underrun", 64'(tx_underrun), 64'(m_under));
        check("tx_full", 64'(tx_full), 64'(tx_q.size() == DEPTH));
        check("rx_valid", 64'(rx_valid), 64'(rx_q.size() > 0));
        check("rx_overflow", 64'(rx_overflow), 64'(m_ovf));
        if (rx_q.size() > 0) check("rx_data", rx_data, rx_q[0]);
    endtask

    // Inputs are already set; model the edge, take it, sample 1 ns later
    task automatic step();
        model_step();
        @(posedge clock);
        #1;
        check_all();
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1; step();
        reset = 1'b1; step();
    endtask

    task automatic push(input logic [63:0] d, input logic [10:0] id, input logic [10:0] rid);
        tx_push = 1'b1; tx_data = d; tx_id = id; tx_rx_id = rid;
    endtask

    initial begin
        clear_inputs();

        // T1 reset
        do_reset();
        check("T1_Tx_ID", 64'(Tx_ID), 64'h7FF);
        check("T1_rx_valid", 64'(rx_valid), 64'h0);
        check("T1_tx_full", 64'(tx_full), 64'h0);
        check("T1_In_packet", In_packet, 64'h0);

        // T2 one frame out, then underrun with done
        push(64'hFFFFEEEE0000FEF1, 11'h001, 11'h7FF); step();
        data_in_req = 1'b1; step();
        check("T2_In_packet", In_packet, 64'hFFFFEEEE0000FEF1);
        check("T2_Tx_ID", 64'(Tx_ID), 64'h001);
        check("T2_Rx_ID", 64'(Rx_ID), 64'h7FF);
        data_in_req = 1'b1; step();
        check("T2_done", 64'(tx_done), 64'h1);
        check("T2_underrun", 64'(tx_underrun), 64'h1);
        check("T2_idle_id", 64'(Tx_ID), 64'h7FF);

        // T3 retry limit
        do_reset();
        push(64'hAAAABBBBCCCC0021, 11'h111, 11'h10A); step();
        data_in_req = 1'b1; step();
        for (int k = 0; k < 3; k++) begin
            Retransmit = 1'b1; step();
            check("T3_no_abort", 64'(tx_abort), 64'h0);
            check("T3_held", In_packet, 64'hAAAABBBBCCCC0021);
`ifdef RETX_PRIO_EN
            check("T3_prio_id", 64'(Tx_ID), 64'h000);
`else
            check("T3_keep_id", 64'(Tx_ID), 64'h111);
`endif
        end
        Retransmit = 1'b1; step();
        check("T3_abort", 64'(tx_abort), 64'h1);
        check("T3_idle_id", 64'(Tx_ID), 64'h7FF);

        // T4 TX full behaviour
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            push(64'h4000 + 64'(k), 11'(k), 11'(k)); step();
        end
        check("T4_full", 64'(tx_full), 64'h1);
        push(64'h4005, 11'h5, 11'h5); step();
        push(64'h4006, 11'h6, 11'h6); data_in_req = 1'b1; step();
        check("T4_full_kept", 64'(tx_full), 64'h1);
        for (int k = 0; k < 4; k++) begin
            data_in_req = 1'b1; step();
        end
        check("T4_last_entry", In_packet, 64'h4006);

        // T5 RX overflow and drain
        do_reset();
        for (int k = 0; k < 5; k++) begin
            data_out_req = 1'b1; Rx_packet = 64'h5000 + 64'(k); step();
        end
        check("T5_ovf", 64'(rx_overflow), 64'h1);
        check("T5_head", rx_data, 64'h5000);
        rx_ovf_clr = 1'b1; step();
        check("T5_ovf_clr", 64'(rx_overflow), 64'h0);
        for (int k = 0; k < 4; k++) begin
            check("T5_order", rx_data, 64'h5000 + 64'(k));
            rx_pop = 1'b1; step();
        end
        check("T5_empty", 64'(rx_valid), 64'h0);

        // T6 request beats Retransmit; retry count restarts on the new frame
        do_reset();
        push(64'h61, 11'h061, 11'h001); step();
        push(64'h62, 11'h062, 11'h002); step();
        data_in_req = 1'b1; step();
        Retransmit = 1'b1; step();
        data_in_req = 1'b1; Retransmit = 1'b1; step();
        check("T6_done", 64'(tx_done), 64'h1);
        check("T6_next", In_packet, 64'h62);
        for (int k = 0; k < 3; k++) begin
            Retransmit = 1'b1; step();
            check("T6_no_abort", 64'(tx_abort), 64'h0);
        end
        Retransmit = 1'b1; step();
        check("T6_abort", 64'(tx_abort), 64'h1);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 299) == 0);
            tx_push      = ($urandom_range(0, 2) == 0);
            tx_data      = {$urandom, $urandom};
            tx_id        = 11'($urandom);
            tx_rx_id     = 11'($urandom);
            rx_pop       = ($urandom_range(0, 2) == 0);
            rx_ovf_clr   = ($urandom_range(0, 9) == 0);
            data_in_req  = ($urandom_range(0, 3) == 0);
            data_out_req = ($urandom_range(0, 2) == 0);
            Rx_packet    = {$urandom, $urandom};
            Retransmit   = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
